// File: rtl/entry_fd.sv
// One MMCAM matching entry: holds a waiting token key and pulses FIRE when its partner arrives.
// VALID/FIRE are registered one CP edge after the EN sample; no backpressure, since ignored tokens are simply dropped.
module entry_fd #(
  parameter int COLOR_W = 6,
  parameter int GEN_W   = 6,
  parameter int DEST_W  = 6
) (
  input  logic                             CP,
  input  logic                             MR,
  input  logic                             EN,
  input  logic [COLOR_W+GEN_W+DEST_W:0]    COLOR_GEN_DEST_LR,
  output logic                             VALID,
  output logic                             FIRE
);

  localparam int KEY_W = COLOR_W + GEN_W + DEST_W;

  typedef enum logic {
    EMPTY   = 1'b0,
    WAITING = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [KEY_W-1:0]   key, key_nxt;
  logic               side, side_nxt;
  logic               fire, fire_nxt;
  logic [KEY_W-1:0]   tok_key;
  logic               tok_side;
  logic               match;

  assign tok_key  = COLOR_GEN_DEST_LR[KEY_W:1];
  assign tok_side = COLOR_GEN_DEST_LR[0];
  assign match    = (state == WAITING) && (tok_key == key) && (tok_side != side);

  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state <= EMPTY;
      key   <= '0;
      side  <= 1'b0;
      fire  <= 1'b0;
    end else begin
      state <= state_nxt;
      key   <= key_nxt;
      side  <= side_nxt;
      fire  <= fire_nxt;
    end
  end

  // Duplicates and foreign keys fall through with state held and FIRE low.
  always_comb begin
    state_nxt = state;
    key_nxt   = key;
    side_nxt  = side;
    fire_nxt  = 1'b0;
    if (EN) begin
      case (state)
        EMPTY: begin
          key_nxt   = tok_key;
          side_nxt  = tok_side;
          state_nxt = WAITING;
        end
        WAITING: begin
          if (match) begin
            fire_nxt  = 1'b1;
            state_nxt = EMPTY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  assign VALID = (state == WAITING);
  assign FIRE  = fire;

endmodule

// File: tb/tb_entry_fd.sv
// Directed bench for entry_fd: store, match, ignore, async reset and back-to-back cases.
module tb_entry_fd;

  logic        CP;
  logic        MR;
  logic        EN;
  logic [18:0] COLOR_GEN_DEST_LR;
  logic        VALID;
  logic        FIRE;

  int checks = 0;
  int errors = 0;

  entry_fd dut (
    .CP                (CP),
    .MR                (MR),
    .EN                (EN),
    .COLOR_GEN_DEST_LR (COLOR_GEN_DEST_LR),
    .VALID             (VALID),
    .FIRE              (FIRE)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic en, input logic [18:0] tok);
    EN = en;
    COLOR_GEN_DEST_LR = tok;
    @(posedge CP);
    #1;
  endtask

  task automatic test_reset;
    MR = 1'b0;
    EN = 1'b1;
    COLOR_GEN_DEST_LR = 19'd120;
    #1;
    checks++;
    if ({VALID, FIRE} !== 2'b00) begin
      errors++;
      $display("FAIL reset_initial: VALID=%b FIRE=%b, want VALID=0 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd120);
    step(1'b1, 19'd120);
    checks++;
    if ({VALID, FIRE} !== 2'b00) begin
      errors++;
      $display("FAIL reset_held: VALID=%b FIRE=%b, want VALID=0 FIRE=0", VALID, FIRE);
    end
    #2 MR = 1'b1;
    EN = 1'b0;
  endtask

  task automatic test_async_reset;
    step(1'b1, 19'd120);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL arst_store: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    EN = 1'b0;
    #2 MR = 1'b0;
    #1;
    checks++;
    if ({VALID, FIRE} !== 2'b00) begin
      errors++;
      $display("FAIL arst_waiting: VALID=%b FIRE=%b, want VALID=0 FIRE=0", VALID, FIRE);
    end
    #1 MR = 1'b1;
    // Reset while FIRE is high must also clear it immediately.
    step(1'b1, 19'd120);
    step(1'b1, 19'd121);
    checks++;
    if ({VALID, FIRE} !== 2'b01) begin
      errors++;
      $display("FAIL arst_pre_fire: VALID=%b FIRE=%b, want VALID=0 FIRE=1", VALID, FIRE);
    end
    EN = 1'b0;
    #2 MR = 1'b0;
    #1;
    checks++;
    if ({VALID, FIRE} !== 2'b00) begin
      errors++;
      $display("FAIL arst_fire: VALID=%b FIRE=%b, want VALID=0 FIRE=0", VALID, FIRE);
    end
    #1 MR = 1'b1;
    step(1'b0, 19'd0);
  endtask

  task automatic test_store_match;
    step(1'b1, 19'd120);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL store_120: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd121);
    checks++;
    if ({VALID, FIRE} !== 2'b01) begin
      errors++;
      $display("FAIL match_121: VALID=%b FIRE=%b, want VALID=0 FIRE=1", VALID, FIRE);
    end
    step(1'b0, 19'd121);
    checks++;
    if ({VALID, FIRE} !== 2'b00) begin
      errors++;
      $display("FAIL fire_one_cycle: VALID=%b FIRE=%b, want VALID=0 FIRE=0", VALID, FIRE);
    end
  endtask

  task automatic test_ignore;
    step(1'b1, 19'd120);
    step(1'b1, 19'd110);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL ignore_other_key: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd120);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL ignore_duplicate: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    // Key 55/L was not stored: its partner must not fire, the held 120 must.
    step(1'b1, 19'd111);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL ignore_not_stored: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd121);
    checks++;
    if ({VALID, FIRE} !== 2'b01) begin
      errors++;
      $display("FAIL ignore_then_match: VALID=%b FIRE=%b, want VALID=0 FIRE=1", VALID, FIRE);
    end
    step(1'b0, 19'd0);
  endtask

  task automatic test_en_low;
    step(1'b1, 19'd120);
    step(1'b0, 19'd121);
    step(1'b0, 19'd121);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL en_low_no_fire: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd121);
    checks++;
    if ({VALID, FIRE} !== 2'b01) begin
      errors++;
      $display("FAIL en_high_fire: VALID=%b FIRE=%b, want VALID=0 FIRE=1", VALID, FIRE);
    end
  endtask

  task automatic test_back_to_back;
    // Entry is empty right after the match above, so token 5 is stored.
    step(1'b1, 19'd5);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_store: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd4);
    checks++;
    if ({VALID, FIRE} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_match_4: VALID=%b FIRE=%b, want VALID=0 FIRE=1", VALID, FIRE);
    end
    step(1'b1, 19'd120);
    step(1'b1, 19'd121 | (19'd1 << 13));
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL color_differs: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd121 | (19'd1 << 7));
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL gen_differs: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd121);
    step(1'b1, 19'd121);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL restore_after_match: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd120);
    checks++;
    if ({VALID, FIRE} !== 2'b01) begin
      errors++;
      $display("FAIL match_r_then_l: VALID=%b FIRE=%b, want VALID=0 FIRE=1", VALID, FIRE);
    end
  endtask

  task automatic test_zero_key;
    step(1'b1, 19'd0);
    checks++;
    if ({VALID, FIRE} !== 2'b10) begin
      errors++;
      $display("FAIL zero_store: VALID=%b FIRE=%b, want VALID=1 FIRE=0", VALID, FIRE);
    end
    step(1'b1, 19'd1);
    checks++;
    if ({VALID, FIRE} !== 2'b01) begin
      errors++;
      $display("FAIL zero_match: VALID=%b FIRE=%b, want VALID=0 FIRE=1", VALID, FIRE);
    end
    step(1'b0, 19'd0);
    checks++;
    if ({VALID, FIRE} !== 2'b00) begin
      errors++;
      $display("FAIL zero_idle: VALID=%b FIRE=%b, want VALID=0 FIRE=0", VALID, FIRE);
    end
  endtask

  initial begin
    test_reset;
    test_async_reset;
    test_store_match;
    test_ignore;
    test_en_low;
    test_back_to_back;
    test_zero_key;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
